// File: rtl/pipe_ctrl_v2_if.sv
// Bus between the pipeline control unit and its surroundings.
// The slave side is the controller. It receives the hold, interrupt,
// jump and halt requests and drives the stall code, the PC redirect,
// the acknowledges and the status signals.
// The master side is the ex/clint/rib/jtag/pc_reg group, or a bench.
interface pipe_ctrl_v2_if #(
  parameter int ADDR_W = 32,
  parameter int N_HOLD = 3,
  parameter int N_INT  = 4
);
  logic                  jump_flag_i;
  logic [ADDR_W-1:0]     jump_addr_i;
  logic [N_HOLD-1:0]     hold_req_i;
  logic [2*N_HOLD-1:0]   hold_lvl_i;
  logic [N_INT-1:0]      int_req_i;
  logic                  int_ret_i;
  logic [ADDR_W-1:0]     int_return_addr_i;
  logic                  halt_req_i;
  logic [N_INT-1:0]      int_ack_o;
  logic                  halt_ack_o;
  logic [2:0]            hold_flag_o;
  logic                  jump_flag_o;
  logic [ADDR_W-1:0]     jump_addr_o;
  logic                  busy_o;

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_req_i, hold_lvl_i,
           int_req_i, int_ret_i, int_return_addr_i, halt_req_i,
    output int_ack_o, halt_ack_o, hold_flag_o, jump_flag_o,
           jump_addr_o, busy_o
  );

  modport master (
    output jump_flag_i, jump_addr_i, hold_req_i, hold_lvl_i,
           int_req_i, int_ret_i, int_return_addr_i, halt_req_i,
    input  int_ack_o, halt_ack_o, hold_flag_o, jump_flag_o,
           jump_addr_o, busy_o
  );
endinterface

// File: rtl/pipe_ctrl_v2.sv
// Pipeline control unit for the tinyriscv core.
// It merges the hold requesters into a single stall code.
// It selects the same-cycle PC redirect from three sources, in this
// order: mret, vectored interrupt, EX jump.
// After every redirect it holds ID for a fixed flush window.
// It also runs the JTAG halt handshake.
// The redirect and the stall code are combinational, so a redirect
// has no added latency. busy_o and halt_ack_o are registered.
module pipe_ctrl_v2 #(
  parameter int                 ADDR_W       = 32,
  parameter int                 N_HOLD       = 3,
  parameter int                 N_INT        = 4,
  parameter logic [ADDR_W-1:0]  INT_BASE     = ADDR_W'(32'h4),
  parameter logic [ADDR_W-1:0]  INT_STRIDE   = ADDR_W'(32'h4),
  parameter int                 FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_ctrl_v2_if.slave      bus
);

  localparam int             CNT_W    = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]     LVL_NONE = 2'd0;
  localparam logic [1:0]     LVL_ID   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q;
  logic               halt_ack_q;

  logic [1:0]         agg_lvl_s;
  logic [1:0]         hold_lvl_s;
  logic               int_any_s;
  logic [N_INT-1:0]   int_sel_s;
  logic [ADDR_W-1:0]  int_addr_s;
  logic               redirect_s;
  logic [ADDR_W-1:0]  redir_addr_s;
  logic [N_INT-1:0]   ack_s;

  function automatic logic [1:0] max_lvl(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Deepest hold depth among the requesters that are currently asserted
  always_comb begin
    agg_lvl_s = LVL_NONE;
    for (int i = 0; i < N_HOLD; i++) begin
      if (bus.hold_req_i[i]) begin
        agg_lvl_s = max_lvl(agg_lvl_s, bus.hold_lvl_i[2*i +: 2]);
      end else begin
        agg_lvl_s = agg_lvl_s;
      end
    end
  end

  // Lowest-index pending interrupt: one-hot select and vector address
  // (descending scan so the lowest index is written last and wins)
  always_comb begin
    int_any_s  = 1'b0;
    int_sel_s  = '0;
    int_addr_s = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (bus.int_req_i[i]) begin
        int_any_s    = 1'b1;
        int_sel_s    = '0;
        int_sel_s[i] = 1'b1;
        int_addr_s   = INT_BASE + ADDR_W'(i) * INT_STRIDE;
      end else begin
        int_any_s    = int_any_s;
      end
    end
  end

  // Redirect priority: mret, then an interrupt (RUN only), then an EX jump
  always_comb begin
    redirect_s   = 1'b0;
    redir_addr_s = '0;
    ack_s        = '0;
    if (bus.int_ret_i) begin
      redirect_s   = 1'b1;
      redir_addr_s = bus.int_return_addr_i;
    end else if (int_any_s && (state_q == ST_RUN)) begin
      redirect_s   = 1'b1;
      redir_addr_s = int_addr_s;
      ack_s        = int_sel_s;
    end else if (bus.jump_flag_i) begin
      redirect_s   = 1'b1;
      redir_addr_s = bus.jump_addr_i;
    end else begin
      redirect_s   = 1'b0;
    end
  end

  // Final stall code: the controller forces Hold_Id on redirects, in FLUSH and in HALTED
  always_comb begin
    if (redirect_s || (state_q != ST_RUN)) begin
      hold_lvl_s = LVL_ID;
    end else begin
      hold_lvl_s = agg_lvl_s;
    end
  end

  // Next state and flush counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_s) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end else if (bus.halt_req_i) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (redirect_s) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q <= CNT_ONE) begin
          // A count of zero cannot occur here. It is treated as the
          // last cycle so that the FSM can never get stuck in FLUSH.
          cnt_d   = '0;
          state_d = bus.halt_req_i ? ST_HALTED : ST_RUN;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ST_FLUSH;
        end
      end
      ST_HALTED: begin
        if (redirect_s) begin
          state_d = ST_HALTED;
          cnt_d   = CNT_LOAD;
        end else if (bus.halt_req_i) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, flush counter and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != ST_RUN);
      halt_ack_q <= (state_d == ST_HALTED);
    end
  end

  // The combinational outputs are gated by reset, so every output reads 0 while rst is low
  assign bus.hold_flag_o = rst ? {1'b0, hold_lvl_s} : 3'b000;
  assign bus.jump_flag_o = rst ? redirect_s : 1'b0;
  assign bus.jump_addr_o = rst ? redir_addr_s : '0;
  assign bus.int_ack_o   = rst ? ack_s : '0;
  assign bus.busy_o      = busy_q;
  assign bus.halt_ack_o  = halt_ack_q;

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Testbench for pipe_ctrl_v2 with FLUSH_CYCLES=2.
// Inputs are driven 1 ns after the rising edge, and the expected output
// set is pushed to a scoreboard at the same time.
// On the falling edge the bench pops the scoreboard and compares.
module tb_pipe_ctrl_v2;
  localparam int ADDR_W = 32;
  localparam int N_HOLD = 3;
  localparam int N_INT  = 4;
  localparam int FC     = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_v2_if #(.ADDR_W(ADDR_W), .N_HOLD(N_HOLD), .N_INT(N_INT)) bus ();

  pipe_ctrl_v2 #(
    .ADDR_W(ADDR_W), .N_HOLD(N_HOLD), .N_INT(N_INT),
    .INT_BASE(32'h4), .INT_STRIDE(32'h4), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic [3:0]  ack;
    logic        busy;
    logic        halt;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc_n        = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic jf, input logic [31:0] ja, input logic [2:0] hr,
                       input logic [5:0] hl, input logic [3:0] ir, input logic iret,
                       input logic [31:0] ira, input logic halt);
    bus.jump_flag_i       = jf;
    bus.jump_addr_i       = ja;
    bus.hold_req_i        = hr;
    bus.hold_lvl_i        = hl;
    bus.int_req_i         = ir;
    bus.int_ret_i         = iret;
    bus.int_return_addr_i = ira;
    bus.halt_req_i        = halt;
  endtask

  task automatic compare();
    exp_t e;
    check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq($sformatf("c%0d hold_flag", e.cyc), 64'(bus.hold_flag_o), 64'(e.hold));
      check_eq($sformatf("c%0d jump_flag", e.cyc), 64'(bus.jump_flag_o), 64'(e.jf));
      check_eq($sformatf("c%0d jump_addr", e.cyc), 64'(bus.jump_addr_o), 64'(e.ja));
      check_eq($sformatf("c%0d int_ack", e.cyc),   64'(bus.int_ack_o),   64'(e.ack));
      check_eq($sformatf("c%0d busy", e.cyc),      64'(bus.busy_o),      64'(e.busy));
      check_eq($sformatf("c%0d halt_ack", e.cyc),  64'(bus.halt_ack_o),  64'(e.halt));
    end
  endtask

  task automatic step(input logic jf, input logic [31:0] ja, input logic [2:0] hr,
                      input logic [5:0] hl, input logic [3:0] ir, input logic iret,
                      input logic [31:0] ira, input logic halt,
                      input logic [2:0] e_hold, input logic e_jf, input logic [31:0] e_ja,
                      input logic [3:0] e_ack, input logic e_busy, input logic e_halt);
    exp_t e;
    @(posedge clk);
    #1;
    drive(jf, ja, hr, hl, ir, iret, ira, halt);
    cyc_n++;
    e = '{cyc_n, e_hold, e_jf, e_ja, e_ack, e_busy, e_halt};
    sb_q.push_back(e);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input logic [2:0] e_hold, input logic e_busy, input logic e_halt);
    step(1'b0, 32'h0, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b0,
         e_hold, 1'b0, 32'h0, 4'h0, e_busy, e_halt);
  endtask

  task automatic halt_cyc(input logic h, input logic [3:0] ir, input logic [2:0] e_hold,
                          input logic [3:0] e_ack, input logic e_jf, input logic [31:0] e_ja,
                          input logic e_busy, input logic e_halt);
    step(1'b0, 32'h0, 3'b000, 6'h00, ir, 1'b0, 32'h0, h,
         e_hold, e_jf, e_ja, e_ack, e_busy, e_halt);
  endtask

  initial begin
    drive(1'b0, 32'h0, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b0);
    // Reset held low with every request active: all outputs must be 0
    step(1'b1, 32'h100, 3'b111, 6'h3f, 4'hf, 1'b1, 32'h44, 1'b1,
         3'b000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    idle(3'b000, 1'b0, 1'b0);

    // EX jump: Hold_Id on the jump cycle plus FC cycles, busy for FC cycles
    step(1'b1, 32'h100, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b0,
         3'b011, 1'b1, 32'h100, 4'h0, 1'b0, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b000, 1'b0, 1'b0);

    // Interrupts 1010: channel 1 first (0x8); channel 3 masked until RUN, then 0x10
    halt_cyc(1'b0, 4'b1010, 3'b011, 4'b0010, 1'b1, 32'h8,  1'b0, 1'b0);
    halt_cyc(1'b0, 4'b1000, 3'b011, 4'b0000, 1'b0, 32'h0,  1'b1, 1'b0);
    halt_cyc(1'b0, 4'b1000, 3'b011, 4'b0000, 1'b0, 32'h0,  1'b1, 1'b0);
    halt_cyc(1'b0, 4'b1000, 3'b011, 4'b1000, 1'b1, 32'h10, 1'b0, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b000, 1'b0, 1'b0);

    // mret beats both a pending interrupt and a jump; that interrupt is taken later
    step(1'b1, 32'h200, 3'b000, 6'h00, 4'b0001, 1'b1, 32'h44, 1'b0,
         3'b011, 1'b1, 32'h44, 4'h0, 1'b0, 1'b0);
    halt_cyc(1'b0, 4'b0001, 3'b011, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
    halt_cyc(1'b0, 4'b0001, 3'b011, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0);
    halt_cyc(1'b0, 4'b0001, 3'b011, 4'b0001, 1'b1, 32'h4, 1'b0, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b000, 1'b0, 1'b0);

    // Hold aggregation: {id,-,pc} -> id; drop id -> pc; non-requester ignored
    step(1'b0, 32'h0, 3'b101, 6'b11_00_01, 4'h0, 1'b0, 32'h0, 1'b0,
         3'b011, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b001, 6'b11_00_01, 4'h0, 1'b0, 32'h0, 1'b0,
         3'b001, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 3'b010, 6'b11_10_00, 4'h0, 1'b0, 32'h0, 1'b0,
         3'b010, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idle(3'b000, 1'b0, 1'b0);

    // Halt raised during FLUSH: HALTED entered at the end of the flush window
    step(1'b1, 32'h300, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b0,
         3'b011, 1'b1, 32'h300, 4'h0, 1'b0, 1'b0);
    halt_cyc(1'b1, 4'h0, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    halt_cyc(1'b1, 4'h0, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    halt_cyc(1'b1, 4'h0, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    // A jump while halted passes through and the FSM stays HALTED
    step(1'b1, 32'h400, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b1,
         3'b011, 1'b1, 32'h400, 4'h0, 1'b1, 1'b1);
    halt_cyc(1'b1, 4'b0001, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    halt_cyc(1'b0, 4'b0001, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    halt_cyc(1'b0, 4'b0001, 3'b011, 4'b0001, 1'b1, 32'h4, 1'b0, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b011, 1'b1, 1'b0);
    idle(3'b000, 1'b0, 1'b0);

    // Halt and jump in the same RUN cycle: the jump wins and the halt follows the flush
    step(1'b1, 32'h500, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b1,
         3'b011, 1'b1, 32'h500, 4'h0, 1'b0, 1'b0);
    halt_cyc(1'b1, 4'h0, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    halt_cyc(1'b1, 4'h0, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    halt_cyc(1'b1, 4'h0, 3'b011, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(3'b011, 1'b1, 1'b1);
    idle(3'b000, 1'b0, 1'b0);

    // Halt straight from RUN, then release
    halt_cyc(1'b1, 4'h0, 3'b000, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(3'b011, 1'b1, 1'b1);
    idle(3'b000, 1'b0, 1'b0);

    // Reset in the middle of FLUSH: outputs drop to 0 and no flush remains afterwards
    step(1'b1, 32'h600, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b0,
         3'b011, 1'b1, 32'h600, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1, 32'h700, 3'b111, 6'h3f, 4'hf, 1'b0, 32'h0, 1'b1,
         3'b000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 3'b000, 6'h00, 4'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    idle(3'b000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_ctrl_v2.md
Name: pipe_ctrl_v2

Overview:
- Parametrised pipeline control unit for the tinyriscv core. It replaces the purely combinational hold/jump arbiter.
- Merges an arbitrary number of hold requesters, each with its own hold depth, into one stall code.
- Arbitrates N prioritised interrupt channels with vectored entry addresses, interrupt return and EX-stage jumps.
- Adds a registered post-jump flush window and a JTAG halt handshake FSM. Sits between ex/clint/rib/jtag and pc_reg/if_id/id_ex.

Parameters:
- ADDR_W, 32, width of jump/return/entry addresses
- N_HOLD, 3, number of hold requesters
- N_INT, 4, number of interrupt request channels
- INT_BASE, 32'h4, entry address of channel 0
- INT_STRIDE, 32'h4, address step between channel entries
- FLUSH_CYCLES, 1, extra Hold_Id cycles after any accepted jump (>=1)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- jump_flag_i  in  1  EX branch/jump taken
- jump_addr_i  in  ADDR_W  EX jump target
- hold_req_i  in  N_HOLD  per-requester hold request
- hold_lvl_i  in  2*N_HOLD  per-requester depth, 2 bits each: 0 none, 1 pc, 2 if, 3 id
- int_req_i  in  N_INT  level interrupt requests, held until acked
- int_ret_i  in  1  mret executed
- int_return_addr_i  in  ADDR_W  mepc for return
- halt_req_i  in  1  JTAG halt request (level)
- int_ack_o  out  N_INT  one-hot, one-cycle accept pulse
- halt_ack_o  out  1  core halted
- hold_flag_o  out  3  Hold_None 000 / Hold_Pc 001 / Hold_If 010 / Hold_Id 011
- jump_flag_o  out  1  redirect PC this cycle
- jump_addr_o  out  ADDR_W  redirect target
- busy_o  out  1  state != RUN

Behaviour:
- Reset (rst=0, async): state RUN, flush counter 0. While rst=0, all outputs are 0 and hold_flag_o is Hold_None.
- States: RUN, FLUSH, HALTED.
- Hold aggregation (combinational): agg = max hold_lvl over requesters with hold_req_i=1. Output hold_flag_o = max(agg, fsm_hold). fsm_hold is Hold_Id in FLUSH, in HALTED, and in any cycle with jump_flag_o=1.
- Redirect priority (combinational, same-cycle, zero latency):
  1. int_ret_i: target int_return_addr_i.
  2. Lowest-index int_req_i bit, only when state==RUN: target INT_BASE + idx*INT_STRIDE, computed modulo 2^ADDR_W. int_ack_o[idx]=1 this cycle.
  3. jump_flag_i: target jump_addr_i.
  4. Otherwise jump_flag_o=0 and jump_addr_o=0.
- Interrupt requests are masked in FLUSH and HALTED. They are not lost: they are taken on the first RUN cycle. int_ret_i and jump_flag_i are honoured in every state.
- Any redirect: next state FLUSH and cnt<=FLUSH_CYCLES. The exception is HALTED, which stays HALTED; cnt is still loaded, but it has no visible effect there.
- FLUSH, no new redirect: cnt<=cnt-1. When cnt==1, next state is HALTED if halt_req_i, else RUN.
- FLUSH with a new redirect: cnt reloads to FLUSH_CYCLES (window restarts).
- Net effect: Hold_Id on the jump cycle plus exactly FLUSH_CYCLES following cycles.
- RUN with halt_req_i=1 and no redirect: next state HALTED.
- RUN with halt_req_i and a redirect in the same cycle: the redirect wins and the FSM goes to FLUSH; the halt is taken when FLUSH exits.
- HALTED: halt_ack_o=1 (registered, equal to state==HALTED). halt_req_i=0 gives next state RUN; halt_ack_o falls the following cycle.
- int_ack_o is never asserted outside RUN and is never asserted in the same cycle as int_ret_i.
- Reset mid-FLUSH or mid-HALTED returns immediately to RUN with all outputs 0; there is no pending flush or halt memory.

Test Plan:
- Reset release, all inputs 0 -> hold_flag_o=000, jump_flag_o=0, busy_o=0, halt_ack_o=0.
- FLUSH_CYCLES=2, jump_flag_i=1 one cycle with addr 0x100 -> jump_flag_o=1 and addr 0x100 that cycle; hold_flag_o=011 for 3 consecutive cycles, then 000; busy_o high for 2 cycles.
- int_req_i=4'b1010 in RUN -> int_ack_o=4'b0010, jump_addr_o=0x8; the next RUN cycle with bit3 still set -> int_ack_o=4'b1000, addr 0x10.
- int_ret_i=1 with int_req_i=4'b0001 and jump_flag_i=1 (addr 0x200), return addr 0x44 -> jump_addr_o=0x44, int_ack_o=0.
- hold_req_i=3'b101, lvl {id, -, pc} -> hold_flag_o=011. Then drop the id requester -> 001.
- halt_req_i=1 during FLUSH -> HALTED entered at FLUSH end, halt_ack_o=1. Jump during halt -> passes through, state stays HALTED. Release halt -> RUN next cycle.
